// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator for the 64x64 multiplier.
// Two registered stages: S1 captures the sign-extended operands, S2 holds the
// 33 unshifted 128-bit partial products. Element i carries weight 4^i
// downstream. Valid/ready handshake with backpressure and a synchronous flush.
module booth_pp_gen #(
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [63:0]        in_x,
  input  logic [63:0]        in_y,
  input  logic               in_x_signed,
  input  logic               in_y_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       part_result [33],
  output logic [TAG_W-1:0]   out_tag
);

  // Booth digit times the sign-extended multiplicand, as an exact 128-bit
  // two's-complement value. Negation is done here (invert plus one), so no
  // correction bits have to travel to the tree.
  function automatic logic [127:0] booth_pp(input logic [2:0] bits, input logic [127:0] m);
    logic [127:0] r;
    case (bits)
      3'b000, 3'b111: r = 128'd0;
      3'b001, 3'b010: r = m;
      3'b011:         r = m << 1;
      3'b100:         r = ~(m << 1) + 128'd1;
      3'b101, 3'b110: r = ~m + 128'd1;
      default:        r = 128'd0;
    endcase
    return r;
  endfunction

  logic               s1_valid_r;
  logic [65:0]        x66_r;
  logic [65:0]        y66_r;
  logic [TAG_W-1:0]   s1_tag_r;

  logic               s2_adv_s;
  logic               accept_s;
  logic [66:0]        yext_s;
  logic [127:0]       xsx_s;
  logic [127:0]       pp_next_s [33];

  // S2 can take new data when it is empty or its content is being consumed.
  assign s2_adv_s = !out_valid || out_ready;
  // Flush blocks the concurrent input so nothing survives the kill.
  assign in_ready = !flush && (!s1_valid_r || s2_adv_s);
  assign accept_s = in_valid && in_ready;

  // Valid bits for both stages; only these are reset, flush clears both.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      out_valid  <= 1'b0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (s2_adv_s) begin
        out_valid <= s1_valid_r;
      end
      if (in_ready) begin
        s1_valid_r <= in_valid;
      end
    end
  end

  // S1 datapath capture: extend each operand to 66 bits by its signedness so
  // that the top Booth digit sees the correct sign (or zero) bits.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      x66_r    <= {{2{in_x_signed & in_x[63]}}, in_x};
      y66_r    <= {{2{in_y_signed & in_y[63]}}, in_y};
      s1_tag_r <= in_tag;
    end
  end

  // Booth recoding: digit i looks at y[2i+1], y[2i], y[2i-1] with y[-1] = 0.
  always_comb begin
    yext_s = {y66_r, 1'b0};
    xsx_s  = {{62{x66_r[65]}}, x66_r};
    for (int i = 0; i < 33; i++) begin
      pp_next_s[i] = booth_pp(yext_s[2*i +: 3], xsx_s);
    end
  end

  // S2 datapath: all products and the tag load together, held while stalled.
  always_ff @(posedge clk) begin
    if (s2_adv_s && s1_valid_r) begin
      for (int i = 0; i < 33; i++) begin
        part_result[i] <= pp_next_s[i];
      end
      out_tag <= s1_tag_r;
    end
  end

endmodule

// File: tb/tb_booth_pp_gen.sv
// Self-checking bench for booth_pp_gen: scoreboard model of accepted ops,
// product reference by plain 128-bit multiplication, plus literal checks.
module tb_booth_pp_gen;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready;
  logic [63:0]  in_x, in_y;
  logic         in_x_signed, in_y_signed;
  logic [3:0]   in_tag, out_tag;
  logic         out_valid, out_ready;
  logic [127:0] pr [33];

  booth_pp_gen #(.TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y),
    .in_x_signed(in_x_signed), .in_y_signed(in_y_signed),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .part_result(pr), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    logic        xs;
    logic        ys;
    logic [3:0]  tag;
    int          acc;
  } op_t;

  op_t          q[$];
  logic [3:0]   emitted[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_pr [33];
  logic [3:0]   prev_tag;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] refmul(input logic [63:0] x, input logic [63:0] y,
                                          input logic xs, input logic ys);
    logic [127:0] a, b;
    a = xs ? {{64{x[63]}}, x} : {64'd0, x};
    b = ys ? {{64{y[63]}}, y} : {64'd0, y};
    return a * b;
  endfunction

  function automatic logic [127:0] wsum();
    logic [127:0] s;
    s = 128'd0;
    for (int i = 0; i < 33; i++) s = s + (pr[i] << (2*i));
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: checks handshake and outputs against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      logic exp_ready, exp_valid, same;
      exp_ready = !flush && (q.size() < 2 || out_ready);
      exp_valid = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
      chk("in_ready", {127'd0, in_ready}, {127'd0, exp_ready});
      chk("out_valid", {127'd0, out_valid}, {127'd0, exp_valid});
      if (out_valid && q.size() > 0) begin
        chk("out_tag", {124'd0, out_tag}, {124'd0, q[0].tag});
        chk("wsum", wsum(), refmul(q[0].x, q[0].y, q[0].xs, q[0].ys));
        if (prev_stall) begin
          same = (out_tag == prev_tag);
          for (int i = 0; i < 33; i++) if (pr[i] !== prev_pr[i]) same = 1'b0;
          chk("held_stable", {127'd0, same}, 128'd1);
        end
        if (out_ready) begin
          emitted.push_back(out_tag);
          void'(q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready && !flush;
      for (int i = 0; i < 33; i++) prev_pr[i] = pr[i];
      prev_tag = out_tag;
      if (flush) q.delete();
      else if (in_valid && in_ready)
        q.push_back('{x: in_x, y: in_y, xs: in_x_signed, ys: in_y_signed, tag: in_tag, acc: cyc});
    end
  end

  task automatic send_op(input logic [63:0] x, input logic [63:0] y,
                         input logic xs, input logic ys, input logic [3:0] tag);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_x = x; in_y = y; in_x_signed = xs; in_y_signed = ys; in_tag = tag;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) chk("send_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    bit ok = 1'b0;
    for (int n = 0; n < 10 && !ok; n++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    if (!ok) chk("out_timeout", 128'd0, 128'd1);
  endtask

  task automatic others_zero(input string name, input int from);
    logic nz;
    nz = 1'b0;
    for (int i = from; i < 33; i++) if (pr[i] != 128'd0) nz = 1'b1;
    chk(name, {127'd0, nz}, 128'd0);
  endtask

  initial begin
    int k, acc, nops;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_x = 64'd0; in_y = 64'd0; in_x_signed = 1'b0; in_y_signed = 1'b0; in_tag = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);

    // Unsigned 3 x 5
    send_op(64'd3, 64'd5, 1'b0, 1'b0, 4'd1);
    wait_out();
    chk("u3x5_pp0", pr[0], 128'd3);
    chk("u3x5_pp1", pr[1], 128'd3);
    others_zero("u3x5_rest", 2);
    chk("u3x5_sum", wsum(), 128'd15);

    // Signed -1 x -1
    send_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 4'd2);
    wait_out();
    chk("sm1_pp0", pr[0], 128'd1);
    others_zero("sm1_rest", 1);

    // Unsigned (2^64-1) x 2
    send_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, 4'd3);
    wait_out();
    chk("umax2_pp0", pr[0], 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0002);
    chk("umax2_pp1", pr[1], 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
    others_zero("umax2_rest", 2);
    chk("umax2_sum", wsum(), 128'h1_FFFF_FFFF_FFFF_FFFE);

    // Same operands, both signed: -1 x 2 = -2
    send_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b1, 4'd4);
    wait_out();
    chk("smax2_sum", wsum(), 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
    repeat (3) @(negedge clk);

    // Backpressure: 4 ops against a stalled output
    emitted.delete();
    @(posedge clk); #1 out_ready = 1'b0;
    k = 1; acc = 0;
    repeat (6) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_tag = k[3:0]; in_x = {$urandom, $urandom}; in_y = {$urandom, $urandom};
      in_x_signed = 1'(k); in_y_signed = 1'b0;
      @(negedge clk);
      if (in_ready) begin acc++; k++; end
    end
    chk("bp_accepted", 128'(acc), 128'd2);
    chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    for (int n = 0; n < 20 && k <= 4; n++) begin
      @(negedge clk);
      if (in_ready) k++;
      @(posedge clk); #1;
      in_tag = k[3:0]; in_x = {$urandom, $urandom};
    end
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("bp_count", 128'(emitted.size()), 128'd4);
    for (int i = 0; i < emitted.size() && i < 4; i++)
      chk("bp_order", {124'd0, emitted[i]}, 128'(i + 1));

    // Flush with two ops in flight and a concurrent input
    @(posedge clk); #1 out_ready = 1'b0;
    send_op(64'd7, 64'd9, 1'b0, 1'b0, 4'd5);
    in_valid = 1'b1; in_x = 64'd11; in_y = 64'd13; in_tag = 4'd6;
    @(negedge clk);
    @(posedge clk); #1;
    in_tag = 4'd9; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {127'd0, in_ready}, 128'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", {127'd0, out_valid}, 128'd0);
    send_op(64'd21, 64'd2, 1'b0, 1'b0, 4'd7);
    wait_out();
    chk("post_flush_tag", {124'd0, out_tag}, 128'd7);
    chk("post_flush_sum", wsum(), 128'd42);

    // Reset mid-operation
    @(posedge clk); #1 out_ready = 1'b0;
    send_op(64'd1, 64'd1, 1'b0, 1'b0, 4'd8);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);

    // Random: 10k accepted ops, random out_ready, occasional flush
    nops = 0;
    for (int n = 0; n < 60000 && nops < 10000; n++) begin
      @(posedge clk); #1;
      out_ready   = ($urandom_range(3) != 0);
      in_valid    = ($urandom_range(4) != 0);
      flush       = ($urandom_range(99) == 0);
      in_x_signed = 1'($urandom);
      in_y_signed = 1'($urandom);
      in_tag      = 4'($urandom);
      case ($urandom_range(3))
        0: in_x = 64'hFFFF_FFFF_FFFF_FFFF;
        1: in_x = {1'b1, 63'd0};
        default: in_x = {$urandom, $urandom};
      endcase
      case ($urandom_range(3))
        0: in_y = 64'hFFFF_FFFF_FFFF_FFFF;
        1: in_y = {1'b1, 63'($urandom)};
        default: in_y = {$urandom, $urandom};
      endcase
      @(negedge clk);
      if (in_valid && in_ready) nops++;
    end
    chk("rand_ops", 128'(nops), 128'd10000);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("drain_empty", 128'(q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_pp_gen.md
# booth_pp_gen

Radix-4 Booth partial-product generator for the 64x64 multiplier datapath. It sits directly upstream of the Wallace-tree reduction stage.
- Accepts a pair of 64-bit operands plus signedness flags over a valid/ready handshake.
- Produces the 33 unshifted 128-bit two's-complement partial products that the tree consumes, together with a pass-through tag.
- Two-stage registered pipeline with backpressure and flush.

## Interface
Parameters:
- TAG_W, 4, width of the opaque tag carried alongside each operation (e.g. mul/mulh/mulhsu/mulhu select, consumed after the final adder)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, synchronous, active-low
- flush  input  1  synchronous kill of all in-flight operations
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept an operand pair this cycle
- in_x  input  64  multiplicand
- in_y  input  64  multiplier
- in_x_signed  input  1  1: in_x is two's complement; 0: unsigned
- in_y_signed  input  1  1: in_y is two's complement; 0: unsigned
- in_tag  input  TAG_W  opaque tag
- out_valid  output  1  part_result/out_tag valid
- out_ready  input  1  downstream accepts this cycle
- part_result  output  [127:0] x [32:0]  unshifted partial products; the tree applies shift 2*i to element i
- out_tag  output  TAG_W  tag of the operation on the output

## Operation
- **Stage 1 (S1)**, capture on in_valid && in_ready:
  - X66 = {2{x_signed & in_x[63]}, in_x}.
  - Y66 = {2{y_signed & in_y[63]}, in_y}.
  - Register X66, Y66 and tag; set s1_valid.
- **Stage 2 (S2)**, Booth encode and generate; all 33 products registered together with the tag:
  - Y66 is extended with y[-1] = 0.
  - Digit i (i = 0..32) is taken from {y[2i+1], y[2i], y[2i-1]}:
    - 000 and 111 -> 0
    - 001 and 010 -> +1
    - 011 -> +2
    - 100 -> -2
    - 101 and 110 -> -1
- part_result[i] = d_i * sext128(X66), as a full 128-bit two's-complement value. Negation is exact (invert plus 1 inside this block); no correction bits are emitted.
- Invariant: sum over i of (part_result[i] << 2i), mod 2^128, equals the exact 128-bit product of the signed/unsigned operands.
- Handshake:
  - s2_valid drives out_valid.
  - S2 advances when !s2_valid || out_ready.
  - S1 advances into S2 under the same condition.
  - in_ready = !s1_valid || (S2 advancing).
  - out_valid never drops without out_ready or flush.
  - part_result/out_tag are held stable while out_valid && !out_ready.
- flush: next cycle s1_valid = s2_valid = 0, and the in_valid presented in the flush cycle is not accepted (in_ready forced 0 during flush).
- Datapath registers are not reset and are don't-care when invalid; only the valid bits are reset.

## Timing
- Reset (rst_n low at a clock edge) gives s1_valid = 0 and s2_valid = 0, so out_valid = 0.
  - in_ready = 1 in the first cycle after reset is released.
  - part_result and out_tag are unspecified until the first out_valid.
- Latency: accepted at edge N, out_valid high after edge N+2.
- Throughput: 1 op/cycle with out_ready held high.
- Full: both stages valid and out_ready = 0 gives in_ready = 0.
  - Releasing out_ready gives in_ready = 1 in the same cycle (combinational path out_ready -> in_ready).
- Simultaneous accept and emit in one cycle is legal and loses nothing.
- Reset mid-operation discards all in-flight ops. Flush behaves the same, but rst_n has priority when both are asserted.
- Flush and out_ready in the same cycle: the output is considered consumed only if out_valid && out_ready. It is cleared regardless.

## Test plan
- **Unsigned 3 x 5**: in_x = 3, in_y = 5, both flags 0 -> after 2 cycles:
  - part_result[0] = 3, part_result[1] = 3, all others 0.
  - Weighted sum = 15.
- **Signed -1 x -1**: in_x = in_y = 64'hFFFF_FFFF_FFFF_FFFF, both flags 1 ->
  - part_result[0] = 128'h1, all others 0.
  - Sum = 1.
- **Unsigned (2^64-1) x 2**:
  - part_result[0] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0002.
  - part_result[1] = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF.
  - Weighted sum = 128'h1_FFFF_FFFF_FFFF_FFFE.
  - Same operands with both flags 1 -> sum = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE (-2).
- **Backpressure**:
  - Stream 4 ops with tags 1..4 while out_ready = 0 -> exactly 2 accepted and in_ready = 0.
  - Then out_ready = 1 -> tags 1, 2, 3, 4 emitted in order, none dropped or duplicated, output held stable while stalled.
- **Flush**: flush with 2 ops in flight and in_valid = 1 -> next cycle out_valid = 0. The concurrent input is not accepted, and a following op emerges 2 cycles after its acceptance.
- **Random**: 10k random operands and flag combinations -> weighted sum mod 2^128 matches a reference 128-bit product, with random out_ready.
